// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   // Bit counter width; a 1-bit operand still needs one counter bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/FA_rtl.sv
// Single-bit full adder reused by the bit-serial adder datapath.
module FA_rtl (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic cout,
   output logic sum
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// NBITS-wide adder that runs one full adder over NBITS cycles, LSB first,
// with val/rdy handshakes on both the operand and result sides.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_a,
   input  logic [NBITS-1:0] in_b,
   input  logic             in_cin,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [NBITS-1:0] out_sum,
   output logic             out_cout
);

   localparam int unsigned     CntW    = cnt_width(NBITS);
   localparam logic [CntW-1:0] CntLast = CntW'(NBITS - 1);

   state_e           r_state;
   state_e           w_state_next;
   logic [NBITS-1:0] r_a;
   logic [NBITS-1:0] r_b;
   logic [NBITS-1:0] r_sum;
   logic             r_carry;
   logic [CntW-1:0]  r_cnt;

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic             w_fire;
   logic [NBITS-1:0] w_sum_shift;

   FA_rtl u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .cout (w_fa_cout),
      .sum  (w_fa_sum)
   );

   assign in_rdy   = (r_state == StIdle) && !reset;
   assign out_val  = (r_state == StDone);
   assign out_sum  = r_sum;
   assign out_cout = r_carry;
   assign w_fire   = in_val && in_rdy;

   // New sum bit enters at the MSB so the LSB lands at bit 0 after NBITS shifts.
   always_comb begin
      w_sum_shift            = r_sum >> 1;
      w_sum_shift[NBITS-1]   = w_fa_sum;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_fire) w_state_next = StCalc;
         StCalc:  if (r_cnt == CntLast) w_state_next = StDone;
         StDone:  if (out_rdy) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_fire) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_sum   <= '0;
            r_cnt   <= '0;
         end else if (r_state == StCalc) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= w_sum_shift;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CntW'(1);
         end
      end
   end

endmodule
